// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into word-granular data_memory
// accesses, with read-modify-write for sub-word stores and split word-crossing accesses.
module load_store_unit #(
    parameter int DEPTH          = 64,
    parameter bit MISALIGN_SPLIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_is_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_read,
    output logic        mem_write,
    output logic [2:0]  mem_width,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [2:0] {IDLE, RD0, WR0, RD1, WR1, RESP} state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state_reg;
    logic        req_ready_reg;
    logic        resp_valid_reg;
    logic        resp_err_reg;
    logic [31:0] resp_rdata_reg;
    logic        mem_read_reg;
    logic        mem_write_reg;
    logic [31:0] mem_address_reg;
    logic [31:0] mem_write_data_reg;

    logic        is_store_reg;
    logic        unsigned_reg;
    logic [1:0]  off_reg;
    logic [2:0]  size_reg;
    logic [29:0] w0_reg;
    logic [31:0] wdata_reg;
    logic        cross_reg;
    logic [31:0] lo_reg;

    // Decode of the incoming request, evaluated only when accepting in IDLE
    logic [1:0]  req_off;
    logic [2:0]  req_size;
    logic [2:0]  req_end;
    logic [29:0] req_w0;
    logic        req_cross;
    logic        req_illegal;
    logic        req_oob;
    logic        req_err;

    assign req_off  = req_addr[1:0];
    assign req_w0   = req_addr[31:2];
    assign req_size = (req_funct3[1:0] == 2'b00) ? 3'd1 :
                      (req_funct3[1:0] == 2'b01) ? 3'd2 : 3'd4;
    assign req_end   = {1'b0, req_off} + req_size;
    assign req_cross = (req_end > 3'd4);

    always_comb begin
        req_illegal = 1'b0;
        if (req_is_store)
            req_illegal = (req_funct3 >= 3'b011);
        else
            req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                          (req_funct3 == 3'b111);
    end

    assign req_oob = ({2'b00, req_w0} >= DEPTH_W) ||
                     (req_cross && (({2'b00, req_w0} + 32'd1) >= DEPTH_W));
    assign req_err = req_illegal || req_oob || (req_cross && !MISALIGN_SPLIT);

    // Store merge: store bytes shifted into their lanes across the {hi, lo} pair
    logic [63:0] store_shifted;
    logic [7:0]  size_mask;
    logic [7:0]  lane_mask;
    logic [31:0] merged_lo;
    logic [31:0] merged_hi;

    assign store_shifted = {32'b0, wdata_reg} << {off_reg, 3'b000};
    assign size_mask = (size_reg == 3'd1) ? 8'h01 :
                       (size_reg == 3'd2) ? 8'h03 : 8'h0F;
    assign lane_mask = size_mask << off_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign merged_lo[8*gi +: 8] = lane_mask[gi] ? store_shifted[8*gi +: 8]
                                                        : mem_read_data[8*gi +: 8];
            assign merged_hi[8*gi +: 8] = lane_mask[gi+4] ? store_shifted[32+8*gi +: 8]
                                                          : mem_read_data[8*gi +: 8];
        end
    endgenerate

    // Load extraction uses the word arriving this cycle, so the result is ready at the last read
    logic [63:0] load_pair;
    logic [31:0] load_word;
    logic [31:0] load_result;

    assign load_pair = (state_reg == RD1) ? {mem_read_data, lo_reg} : {32'b0, mem_read_data};
    assign load_word = 32'(load_pair >> {off_reg, 3'b000});

    always_comb begin
        load_result = load_word;
        case (size_reg)
            3'd1: load_result = unsigned_reg ? {24'b0, load_word[7:0]}
                                             : {{24{load_word[7]}}, load_word[7:0]};
            3'd2: load_result = unsigned_reg ? {16'b0, load_word[15:0]}
                                             : {{16{load_word[15]}}, load_word[15:0]};
            default: load_result = load_word;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg          <= IDLE;
            req_ready_reg      <= 1'b1;
            resp_valid_reg     <= 1'b0;
            resp_err_reg       <= 1'b0;
            resp_rdata_reg     <= 32'b0;
            mem_read_reg       <= 1'b0;
            mem_write_reg      <= 1'b0;
            mem_address_reg    <= 32'b0;
            mem_write_data_reg <= 32'b0;
            is_store_reg       <= 1'b0;
            unsigned_reg       <= 1'b0;
            off_reg            <= 2'b0;
            size_reg           <= 3'b0;
            w0_reg             <= 30'b0;
            wdata_reg          <= 32'b0;
            cross_reg          <= 1'b0;
            lo_reg             <= 32'b0;
        end else begin
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (req_valid) begin
                        is_store_reg  <= req_is_store;
                        unsigned_reg  <= req_funct3[2];
                        off_reg       <= req_off;
                        size_reg      <= req_size;
                        w0_reg        <= req_w0;
                        wdata_reg     <= req_wdata;
                        cross_reg     <= req_cross;
                        req_ready_reg <= 1'b0;
                        if (req_err) begin
                            state_reg      <= RESP;
                            resp_valid_reg <= 1'b1;
                            resp_err_reg   <= 1'b1;
                            resp_rdata_reg <= 32'b0;
                        end else begin
                            state_reg       <= RD0;
                            mem_read_reg    <= 1'b1;
                            mem_address_reg <= {2'b00, req_w0};
                        end
                    end
                end
                RD0: begin
                    lo_reg <= mem_read_data;
                    if (is_store_reg) begin
                        state_reg          <= WR0;
                        mem_write_reg      <= 1'b1;
                        mem_write_data_reg <= merged_lo;
                    end else if (cross_reg) begin
                        state_reg       <= RD1;
                        mem_read_reg    <= 1'b1;
                        mem_address_reg <= {2'b00, w0_reg} + 32'd1;
                    end else begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= load_result;
                    end
                end
                WR0: begin
                    if (cross_reg) begin
                        state_reg       <= RD1;
                        mem_read_reg    <= 1'b1;
                        mem_address_reg <= {2'b00, w0_reg} + 32'd1;
                    end else begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= 32'b0;
                    end
                end
                RD1: begin
                    if (is_store_reg) begin
                        state_reg          <= WR1;
                        mem_write_reg      <= 1'b1;
                        mem_write_data_reg <= merged_hi;
                    end else begin
                        state_reg      <= RESP;
                        resp_valid_reg <= 1'b1;
                        resp_rdata_reg <= load_result;
                    end
                end
                WR1: begin
                    state_reg      <= RESP;
                    resp_valid_reg <= 1'b1;
                    resp_rdata_reg <= 32'b0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state_reg      <= IDLE;
                        resp_valid_reg <= 1'b0;
                        resp_err_reg   <= 1'b0;
                        resp_rdata_reg <= 32'b0;
                        req_ready_reg  <= 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ready      = req_ready_reg;
    assign resp_valid     = resp_valid_reg;
    assign resp_err       = resp_err_reg;
    assign resp_rdata     = resp_rdata_reg;
    assign mem_read       = mem_read_reg;
    assign mem_write      = mem_write_reg;
    assign mem_width      = 3'b010;
    assign mem_address    = mem_address_reg;
    assign mem_write_data = mem_write_data_reg;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: table of directed transactions against a
// word memory model, plus hand sequences for response stall and mid-operation reset.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_width;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data;

    always #5 clk = ~clk;

    load_store_unit #(.DEPTH(64), .MISALIGN_SPLIT(1'b1)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .mem_read(mem_read), .mem_write(mem_write),
        .mem_width(mem_width), .mem_address(mem_address),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    // Word memory model with combinational read; preload port shares the write process
    logic [31:0] tb_mem [0:63];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = 6'd0;
    logic [31:0] pre_val = 32'd0;
    int          rd_total = 0;
    int          wr_total = 0;

    assign mem_read_data = (mem_address < 32'd64) ? tb_mem[mem_address[5:0]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        if (mem_write && (mem_address < 32'd64))
            tb_mem[mem_address[5:0]] <= mem_write_data;
        else if (pre_en)
            tb_mem[pre_idx] <= pre_val;
    end

    always @(posedge clk) begin
        if (mem_read)  rd_total <= rd_total + 1;
        if (mem_write) wr_total <= wr_total + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [5:0] idx, input logic [31:0] val);
        @(negedge clk);
        pre_en  = 1'b1;
        pre_idx = idx;
        pre_val = val;
        @(posedge clk);
        #1 pre_en = 1'b0;
    endtask

    typedef struct {
        logic        is_store;
        logic [2:0]  funct3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        int          mem_idx;
        logic [31:0] mem_val;
    } vec_t;

    task automatic do_txn(input vec_t v, input int hold, input string tag);
        int  rd0;
        int  wr0;
        int  lat;
        bit  got;
        @(negedge clk);
        check32({tag, " req_ready_idle"}, {31'b0, req_ready}, 32'd1);
        req_valid    = 1'b1;
        req_is_store = v.is_store;
        req_funct3   = v.funct3;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
        rd0 = rd_total;
        wr0 = wr_total;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        lat = 1;
        got = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check32({tag, " rw_exclusive"}, {31'b0, mem_read & mem_write}, 32'd0);
            if (resp_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: resp_valid never rose within 20 cycles", tag);
            return;
        end
        check32({tag, " latency"}, lat, v.exp_lat);
        check32({tag, " resp_err"}, {31'b0, resp_err}, {31'b0, v.exp_err});
        check32({tag, " resp_rdata"}, resp_rdata, v.exp_rdata);
        check32({tag, " req_ready_busy"}, {31'b0, req_ready}, 32'd0);
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check32({tag, " hold_valid"}, {31'b0, resp_valid}, 32'd1);
            check32({tag, " hold_rdata"}, resp_rdata, v.exp_rdata);
            check32({tag, " hold_req_ready"}, {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        check32({tag, " reads"}, rd_total - rd0, v.exp_rd);
        check32({tag, " writes"}, wr_total - wr0, v.exp_wr);
        check32({tag, " resp_valid_drop"}, {31'b0, resp_valid}, 32'd0);
        check32({tag, " req_ready_back"}, {31'b0, req_ready}, 32'd1);
        if (v.mem_idx >= 0)
            check32({tag, " mem_word"}, tb_mem[v.mem_idx], v.mem_val);
        $display("txn %s: store=%0d f3=%0d addr=0x%08h rdata=0x%08h err=%0d lat=%0d rd=%0d wr=%0d",
                 tag, v.is_store, v.funct3, v.addr, resp_rdata, resp_err, lat,
                 rd_total - rd0, wr_total - wr0);
    endtask

    vec_t vecs [16];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //         st    f3      addr          wdata         rdata         err   lat rd wr idx  mem
        vecs[0]  = '{1'b0, 3'b000, 32'h0000_0003, 32'h0,        32'hFFFF_FF80, 1'b0, 2, 1, 0, -1, 32'h0};
        vecs[1]  = '{1'b0, 3'b101, 32'h0000_0001, 32'h0,        32'h0000_FF7F, 1'b0, 2, 1, 0, -1, 32'h0};
        vecs[2]  = '{1'b1, 3'b000, 32'h0000_0006, 32'hFFFF_FFAB, 32'h0,        1'b0, 3, 1, 1,  1, 32'h11AB_3344};
        vecs[3]  = '{1'b0, 3'b010, 32'h0000_000B, 32'h0,        32'h3322_11DD, 1'b0, 3, 2, 0, -1, 32'h0};
        vecs[4]  = '{1'b1, 3'b010, 32'h0000_000B, 32'hCAFE_BABE, 32'h0,        1'b0, 5, 2, 2,  2, 32'hBECC_BBAA};
        vecs[5]  = '{1'b0, 3'b010, 32'h0000_000B, 32'h0,        32'hCAFE_BABE, 1'b0, 3, 2, 0,  3, 32'h44CA_FEBA};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 1, 0, 0, -1, 32'h0};
        vecs[7]  = '{1'b1, 3'b011, 32'h0000_0004, 32'h1234_5678, 32'h0,        1'b1, 1, 0, 0,  1, 32'h11AB_3344};
        vecs[8]  = '{1'b0, 3'b110, 32'h0000_0000, 32'h0,        32'h0,        1'b1, 1, 0, 0, -1, 32'h0};
        vecs[9]  = '{1'b0, 3'b010, 32'h0000_00FD, 32'h0,        32'h0,        1'b1, 1, 0, 0, -1, 32'h0};
        vecs[10] = '{1'b0, 3'b001, 32'h0000_0007, 32'h0,        32'hFFFF_AA11, 1'b0, 3, 2, 0, -1, 32'h0};
        vecs[11] = '{1'b0, 3'b100, 32'h0000_00FC, 32'h0,        32'h0000_00F0, 1'b0, 2, 1, 0, -1, 32'h0};
        vecs[12] = '{1'b1, 3'b001, 32'h0000_0002, 32'h0000_1234, 32'h0,        1'b0, 3, 1, 1,  0, 32'h1234_7F01};
        vecs[13] = '{1'b0, 3'b010, 32'h0000_0000, 32'h0,        32'h1234_7F01, 1'b0, 2, 1, 0, -1, 32'h0};
        vecs[14] = '{1'b1, 3'b100, 32'h0000_0008, 32'h0000_00EE, 32'h0,        1'b1, 1, 0, 0,  2, 32'hBECC_BBAA};
        vecs[15] = '{1'b1, 3'b001, 32'h0000_00F7, 32'h0000_5566, 32'h0,        1'b0, 5, 2, 2, 62, 32'h0000_0055};

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_is_store = 1'b0;
        req_funct3   = 3'b000;
        req_addr     = 32'h0;
        req_wdata    = 32'h0;
        resp_ready   = 1'b0;

        preload(6'd0,  32'h80FF_7F01);
        preload(6'd1,  32'h1122_3344);
        preload(6'd2,  32'hDDCC_BBAA);
        preload(6'd3,  32'h4433_2211);
        preload(6'd4,  32'h1111_1111);
        preload(6'd5,  32'h2222_2222);
        preload(6'd61, 32'h0000_0000);
        preload(6'd62, 32'h0000_0000);
        preload(6'd63, 32'h0000_00F0);

        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check32("rst req_ready", {31'b0, req_ready}, 32'd1);
        check32("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check32("rst resp_err", {31'b0, resp_err}, 32'd0);
        check32("rst resp_rdata", resp_rdata, 32'd0);
        check32("rst mem_read", {31'b0, mem_read}, 32'd0);
        check32("rst mem_write", {31'b0, mem_write}, 32'd0);
        check32("rst mem_width", {29'b0, mem_width}, 32'd2);
        check32("rst mem_address", mem_address, 32'd0);

        for (int i = 0; i < 16; i++)
            do_txn(vecs[i], 0, $sformatf("vec%0d", i));

        // Response stall: LB at 0x3 now sees byte 0x12 of mem[0] = 0x12347F01
        do_txn('{1'b0, 3'b000, 32'h0000_0003, 32'h0, 32'h0000_0012, 1'b0, 2, 1, 0, -1, 32'h0},
               4, "stall");

        // Reset right after the WR0 write of a split SW at 0x13 (words 4 and 5)
        @(negedge clk);
        req_valid    = 1'b1;
        req_is_store = 1'b1;
        req_funct3   = 3'b010;
        req_addr     = 32'h0000_0013;
        req_wdata    = 32'hAABB_CCDD;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check32("split wr0 mem_write", {31'b0, mem_write}, 32'd1);
        check32("split wr0 mem_address", mem_address, 32'd4);
        check32("split wr0 write_data", mem_write_data, 32'hDD11_1111);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check32("midrst mem_read", {31'b0, mem_read}, 32'd0);
        check32("midrst mem_write", {31'b0, mem_write}, 32'd0);
        check32("midrst resp_valid", {31'b0, resp_valid}, 32'd0);
        check32("midrst mem_address", mem_address, 32'd0);
        check32("midrst mem_write_data", mem_write_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check32("midrst req_ready", {31'b0, req_ready}, 32'd1);
        check32("midrst mem4", tb_mem[4], 32'hDD11_1111);
        check32("midrst mem5", tb_mem[5], 32'h2222_2222);
        $display("txn midrst: split store interrupted, mem4=0x%08h mem5=0x%08h",
                 tb_mem[4], tb_mem[5]);

        do_txn('{1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'hDD11_1111, 1'b0, 2, 1, 0, -1, 32'h0},
               0, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
